sr_div: RTL

Iterative multi-cycle integer divider implementing RISC-V M-extension DIV, DIVU, REM and REMU. It is the inverse companion to the single-cycle ALU multiply: the CPU issues operands through a valid/ready handshake, stalls, and then takes the quotient or remainder back through a second handshake. The core is a radix-2 restoring divider: one quotient bit per cycle, with 32 iteration cycles per operation. Divide-by-zero and signed-overflow cases bypass the iteration loop.

---
 rtl/sr_div.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/sr_div.sv
// sr_div: iterative radix-2 restoring divider for RISC-V DIV/DIVU/REM/REMU.
// Operands arrive over a valid/ready handshake. The block produces one
// quotient bit per cycle for 32 cycles. The quotient or remainder is then
// returned through a second valid/ready handshake. Divide-by-zero and signed
// overflow skip the iteration loop and finish on the cycle after accept.
module sr_div (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] srcA,
  input  logic [31:0] srcB,
  input  logic [1:0]  oper,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic [31:0] rem_q;    // partial remainder; always below the divisor, so 32 bits suffice
  logic [31:0] dvd_q;    // dividend shifts out at the top, quotient bits shift in at the bottom
  logic [31:0] dvs_q;    // divisor magnitude
  logic        neg_res;  // final result must be negated
  logic        is_rem;   // return the remainder rather than the quotient

  // Two's-complement magnitude. 0x80000000 maps to itself, which is the
  // correct unsigned magnitude 2^31.
  function automatic logic [31:0] mag(input logic signed [31:0] x);
    logic signed [31:0] n;
    n = -x;
    return x[31] ? 32'(n) : 32'(x);
  endfunction

  // Conditional two's-complement negate used for the final sign correction.
  function automatic logic [31:0] neg_if(input logic [31:0] x, input logic s);
    return s ? (~x + 32'd1) : x;
  endfunction

  // Request side is open only in IDLE and never while reset is asserted.
  assign in_ready = (state == IDLE) && !rst;

  // Special-case detection on the request operands.
  logic        div_zero;
  logic        sgn_ovf;
  logic [31:0] special_res;

  // Classify the incoming request and form the bypass result.
  always_comb begin
    div_zero    = (srcB == 32'd0);
    sgn_ovf     = !oper[0] && (srcA == 32'h8000_0000) && (srcB == 32'hFFFF_FFFF);
    special_res = 32'd0;
    if (div_zero)
      special_res = oper[1] ? srcA : 32'hFFFF_FFFF;
    else
      special_res = oper[1] ? 32'd0 : 32'h8000_0000;
  end

  // One restoring step: shift in the next dividend bit, trial-subtract the
  // divisor, and keep the difference when it does not go negative.
  logic [32:0] r_sh;
  logic        ge;
  logic [31:0] sub;
  logic [31:0] rem_nxt;
  logic [31:0] dvd_nxt;

  // Combinational datapath for a single quotient bit.
  always_comb begin
    r_sh    = {rem_q, dvd_q[31]};
    ge      = (r_sh >= {1'b0, dvs_q});
    // The true difference fits in 32 bits whenever it is kept, so a
    // modulo-2^32 subtract is exact.
    sub     = r_sh[31:0] - dvs_q;
    rem_nxt = ge ? sub : r_sh[31:0];
    dvd_nxt = {dvd_q[30:0], ge};
  end

  // Control FSM and iteration registers, all cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 5'd0;
      rem_q     <= 32'd0;
      dvd_q     <= 32'd0;
      dvs_q     <= 32'd0;
      neg_res   <= 1'b0;
      is_rem    <= 1'b0;
      result    <= 32'd0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            is_rem <= oper[1];
            cnt    <= 5'd0;
            rem_q  <= 32'd0;
            if (div_zero || sgn_ovf) begin
              result    <= special_res;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              if (!oper[0]) begin
                dvd_q   <= mag(srcA);
                dvs_q   <= mag(srcB);
                // The quotient takes the XOR of the operand signs. The
                // remainder takes the dividend's sign.
                neg_res <= oper[1] ? srcA[31] : (srcA[31] ^ srcB[31]);
              end else begin
                dvd_q   <= srcA;
                dvs_q   <= srcB;
                neg_res <= 1'b0;
              end
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          rem_q <= rem_nxt;
          dvd_q <= dvd_nxt;
          cnt   <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            result    <= neg_if(is_rem ? rem_nxt : dvd_nxt, neg_res);
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
